dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Multi-cycle data-memory responder: the memory-side end of the CPU load/store interface.
//  Accepts one read/write request via a valid/ready handshake and holds off further requests.
//  Performs the access after a fixed programmable latency and returns a one-cycle response.
//  Replaces the ideal combinational data memory so CPU stall logic can be exercised.
// PARAMETERS
//  DEPTH    1024  storage size in 32-bit words (power of two)
//  LATENCY  4     cycles from request accept edge to access edge; legal range >= 1
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  req_valid    in   1   requester presents a request
//  req_ready    out  1   responder can accept; a transfer occurs on an edge with valid & ready
//  req_write    in   1   1 = store, 0 = load
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data
//  resp_valid   out  1   response strobe, high for exactly one cycle per accepted request
//  resp_rdata   out  32  load data; 0 for stores and errors
//  resp_error   out  1   request rejected: misaligned or out of range
// BEHAVIOUR
//  - Reset (async): state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_error=0,
//    and all DEPTH words are cleared to 0. While reset is high, req_ready=0.
//  - req_ready = (state==IDLE) & ~reset. Requests are accepted only in IDLE.
//  - FSM:
//    IDLE -> WAIT on accept. Latch addr, write and wdata; counter <= LATENCY-1.
//    WAIT: if counter != 0, counter decrements each cycle.
//          If counter == 0, perform the access on this edge and go to RESP.
//    RESP: resp_valid=1; unconditionally return to IDLE on the next edge. There is no response backpressure.
//  - Timing: accept on edge E0, access on edge E(LATENCY), resp_valid high between E(LATENCY) and E(LATENCY+1).
//    Minimum request spacing is LATENCY+2 cycles.
//  - Validity: latched addr[1:0] != 0, or addr[31:2] >= DEPTH, is an error.
//    On error: no write is performed, resp_error=1, resp_rdata=0, and latency is unchanged.
//  - Store: word[addr[31:2]] <= wdata on the access edge; resp_rdata=0, resp_error=0.
//  - Load: resp_rdata <= word[addr[31:2]] on the access edge; resp_error=0.
//  - resp_rdata and resp_error update only on the access edge and hold until the next access edge.
//  - req_valid while req_ready=0 is ignored. Input changes during WAIT/RESP do not affect the latched request.
//  - Read-after-write to the same word in consecutive transactions returns the new data.
//  - Reset mid-WAIT: the pending access is discarded (no write) and no resp_valid is produced.
//  - Counter width: $clog2(LATENCY+1). It never underflows; it is loaded only on accept.
// STRUCTURE
//  - Shared package mem_pkg:
//    state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
//    WORD_BYTES=4; and a function is_word_aligned(addr).
//  - Sub-module dmem_array: DEPTH x 32 storage.
//    Async-reset clear, synchronous write enable, combinational read by word index.
//  - The top level holds the FSM, the latency counter, the request latch and the error check.
// TESTING (DEPTH=1024, LATENCY=4 unless stated)
//  1. Write addr 0x10, data 0xDEADBEEF.
//     -> req_ready=0 for 5 cycles; resp_valid is a single pulse 4 edges after accept; resp_error=0, resp_rdata=0.
//  2. Read addr 0x10 -> resp_rdata=0xDEADBEEF, resp_error=0, same latency.
//     Read addr 0x14 -> resp_rdata=0.
//  3. Write addr 0x13, data 0x12345678 -> resp_error=1.
//     Then read 0x10 -> still 0xDEADBEEF; read 0x12 -> resp_error=1, rdata=0.
//  4. Read addr 0x1000 (=4*DEPTH) -> resp_error=1, resp_rdata=0.
//     Read 0xFFC -> resp_error=0.
//  5. Hold req_valid=1 continuously with changing addr during WAIT.
//     -> only the first request is serviced; the next is accepted on the first IDLE cycle after the resp_valid cycle.
//  6. Write 0x20 = 0xA5A5A5A5, then assert reset two cycles after accept.
//     -> resp_valid never rises; after reset, read 0x20 returns 0.
//  7. LATENCY=1, back-to-back write/read of 0x40 = 0xCAFEF00D.
//     -> each resp_valid 1 edge after accept; the read returns 0xCAFEF00D; spacing is 3 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t          responder FSM encoding
//   WORD_BYTES       bytes per storage word
//   is_word_aligned  true when a byte address falls on a word boundary
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_OFS_W = $clog2(WORD_BYTES);

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[BYTE_OFS_W-1:0] == '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage.
//   clk, reset  clock / async active-high clear of every word
//   we          write enable (sampled on rising clk)
//   idx         word index, shared by read and write
//   wdata       write data
//   rdata       combinational read of word[idx]
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem <= '{default: '0};
    else if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder (memory side of the CPU load/store port).
// One request is accepted in IDLE, held for LATENCY edges, then the access
// happens and resp_valid strobes for one cycle.
//   clk, reset               clock / async active-high reset
//   req_valid, req_ready     request handshake (transfer on valid & ready)
//   req_write, req_addr,
//   req_wdata                store flag, byte address, store data
//   resp_valid               one-cycle response strobe
//   resp_rdata, resp_error   load data (0 for stores/errors), reject flag
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY+1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   lat_addr, lat_wdata;
  logic          lat_write;
  logic          accept, access, err, we;
  logic [31:0]   rd_word;

  assign req_ready  = (state == IDLE) & ~reset;
  assign resp_valid = (state == RESP);
  assign accept     = req_valid & req_ready;
  assign access     = (state == WAIT) && (cnt == '0);

  // Range check on the full word index so addresses past DEPTH never alias.
  assign err = !is_word_aligned(lat_addr) || (lat_addr[31:2] >= 30'(DEPTH));
  assign we  = access & lat_write & ~err;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .idx   (lat_addr[AW+1:2]),
    .wdata (lat_wdata),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latency counter: loaded only on accept, counts down to 0 in WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          cnt <= '0;
    else if (accept)                    cnt <= CW'(LATENCY-1);
    else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
    end else if (accept) begin
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_write <= req_write;
    end
  end

  // Response data/flag change only on the access edge and hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else if (access) begin
      resp_error <= err;
      resp_rdata <= (err || lat_write) ? 32'h0 : rd_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;  // 0: LATENCY=4 instance, 1: LATENCY=1 instance
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;

  logic        rdy_a, rv_a, err_a, rdy_b, rv_b, err_b;
  logic [31:0] rd_a, rd_b;
  logic        rdy, rv, err;
  logic [31:0] rd;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .LATENCY(4)) dut_a (
    .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rdy_a),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_a), .resp_rdata(rd_a), .resp_error(err_a));

  dmem_responder #(.DEPTH(1024), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rdy_b),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv_b), .resp_rdata(rd_b), .resp_error(err_b));

  assign rdy = sel ? rdy_b : rdy_a;
  assign rv  = sel ? rv_b  : rv_a;
  assign rd  = sel ? rd_b  : rd_a;
  assign err = sel ? err_b : err_a;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // One transaction: wait for ready, accept, then watch until ready returns.
  // lat = post-accept edge where resp_valid is seen, pulses = number of
  // resp_valid cycles, rdy_at = post-accept edge where ready is high again.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rdata, output logic e,
                     output int lat, output int pulses, output int rdy_at);
    int n;
    rdata = 'x; e = 1'bx; lat = -1; pulses = 0; rdy_at = -1;
    n = 0;
    while (!rdy && n < 30) begin @(posedge clk); #1; n++; end
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hFFFF_FFF1; req_wdata = 32'h0BAD_0BAD;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (rv) begin
        pulses++;
        if (lat < 0) begin lat = c; rdata = rd; e = err; end
      end
      if (rdy) begin rdy_at = c; break; end
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] r; logic e; int lat, pul, ra;
    logic        rv_h [0:11];
    logic        rdy_h[0:11];
    logic [31:0] rd_h [0:11];
    bit          seen;

    sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(rdy_a), 0);
    check("reset_rv",    32'(rv_a), 0);
    check("reset_rdata", rd_a, 0);
    check("reset_err",   32'(err_a), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_ready", 32'(rdy_a), 1);

    // Tests 1-4
    vecs.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h14,   32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'h13,   32'h12345678, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h12,   32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b1, 32'h1000, 32'h55555555, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h1000, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 32'h0,    32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'hFFC,  32'h0,        32'h0,        1'b0});
    vecs.push_back('{1'b1, 32'hFFC,  32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 32'hFFC,  32'h0,        32'h11223344, 1'b0});

    foreach (vecs[i]) begin
      txn(vecs[i].w, vecs[i].addr, vecs[i].wdata, r, e, lat, pul, ra);
      check($sformatf("v%0d_rdata", i), r, vecs[i].exp_rd);
      check($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_lat", i), lat, 4);
      check($sformatf("v%0d_pulses", i), pul, 1);
      check($sformatf("v%0d_busy", i), ra, 5);
    end

    // Test 5: valid held high, address changing during WAIT/RESP.
    while (!rdy) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    rv_h[0] = rv; rdy_h[0] = rdy; rd_h[0] = rd;
    req_addr = 32'h14;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      rv_h[c] = rv; rdy_h[c] = rdy; rd_h[c] = rd;
      if (rdy) req_addr = 32'hFFC;
      else     req_addr = 32'h14 + 32'(c);
      if (c >= 10) req_valid = 1'b0;
    end
    for (int c = 0; c <= 4; c++) check($sformatf("t5_busy%0d", c), 32'(rdy_h[c]), 0);
    check("t5_ready_after_resp", 32'(rdy_h[5]), 1);
    check("t5_second_accepted", 32'(rdy_h[6]), 0);
    for (int c = 0; c <= 11; c++)
      check($sformatf("t5_rv%0d", c), 32'(rv_h[c]), (c == 4 || c == 10) ? 1 : 0);
    check("t5_first_rdata", rd_h[4], 32'hDEADBEEF);
    check("t5_second_rdata", rd_h[10], 32'h11223344);

    // Test 6: reset two edges after accept discards the pending write.
    while (!rdy) begin @(posedge clk); #1; end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; seen |= rv; end
    reset = 1'b1;
    #1;
    check("t6_ready_in_reset", 32'(rdy), 0);
    repeat (2) begin @(posedge clk); #1; seen |= rv; end
    reset = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen |= rv; end
    check("t6_no_resp", 32'(seen), 0);
    txn(1'b0, 32'h20, 32'h0, r, e, lat, pul, ra);
    check("t6_read_cleared", r, 32'h0);
    txn(1'b0, 32'h10, 32'h0, r, e, lat, pul, ra);
    check("t6_other_cleared", r, 32'h0);

    // Test 7: LATENCY=1 instance, back-to-back write/read.
    sel = 1'b1;
    #1;
    txn(1'b1, 32'h40, 32'hCAFEF00D, r, e, lat, pul, ra);
    check("t7_w_lat", lat, 1);
    check("t7_w_rdata", r, 32'h0);
    check("t7_w_spacing", ra + 1, 3);
    txn(1'b0, 32'h40, 32'h0, r, e, lat, pul, ra);
    check("t7_r_lat", lat, 1);
    check("t7_r_rdata", r, 32'hCAFEF00D);
    check("t7_r_err", 32'(e), 0);
    check("t7_r_pulses", pul, 1);
    check("t7_r_spacing", ra + 1, 3);
    txn(1'b0, 32'h41, 32'h0, r, e, lat, pul, ra);
    check("t7_mis_err", 32'(e), 1);
    check("t7_mis_lat", lat, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
